// File: rtl/ghash_pkg.sv
// Shared GHASH datapath definitions: operand/product widths, multiplier FSM
// states and the field polynomial used by the reduction stage.
package ghash_pkg;

    localparam int GF_W   = 128;
    localparam int PROD_W = 256;

    // x^128 + x^7 + x^2 + x + 1, with the x^128 term implied
    localparam logic [GF_W-1:0] GF_POLY = 128'h87;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/clmul_digit.sv
// Carry-less partial product of the shifted multiplicand and one digit of b.
// Pure combinational; the caller guarantees no needed bit moves past 254.
module clmul_digit
    import ghash_pkg::*;
#(
    parameter int DIGIT_W = 8
) (
    input  logic [PROD_W-2:0]  a_sh,
    input  logic [DIGIT_W-1:0] digit,
    output logic [PROD_W-2:0]  pp
);

    always_comb begin
        pp = '0;
        for (int j = 0; j < DIGIT_W; j++) begin
            if (digit[j]) begin
                pp = pp ^ (a_sh << j);
            end
        end
    end

endmodule

// File: rtl/clmul_iter.sv
// Iterative GF(2)[x] 128x128 carry-less multiplier, DIGIT_W bits of b per cycle.
// Define CLMUL_EARLY_EXIT_EN to finish as soon as the remaining b digits are zero.
module clmul_iter
    import ghash_pkg::*;
#(
    parameter int DIGIT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [GF_W-1:0]   a,
    input  logic [GF_W-1:0]   b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] product,
    output logic              busy
);

    localparam int K     = GF_W / DIGIT_W;
    localparam int AW    = PROD_W - 1;
    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

    state_t           state;
    logic [AW-1:0]    a_sh;
    logic [AW-1:0]    acc;
    logic [AW-1:0]    pp;
    logic [GF_W-1:0]  b_sh;
    logic [GF_W-1:0]  b_next;
    logic [CNT_W-1:0] cnt;
    logic             last;

    assign b_next  = b_sh >> DIGIT_W;
    assign product = {1'b0, acc};

`ifdef CLMUL_EARLY_EXIT_EN
    assign last = (cnt == CNT_W'(K - 1)) || (b_next == '0);
`else
    assign last = (cnt == CNT_W'(K - 1));
`endif

    clmul_digit #(
        .DIGIT_W(DIGIT_W)
    ) u_digit (
        .a_sh (a_sh),
        .digit(b_sh[DIGIT_W-1:0]),
        .pp   (pp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            acc       <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= {{(AW - GF_W){1'b0}}, a};
                        b_sh     <= b;
                        acc      <= '0;
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    acc  <= acc ^ pp;
                    a_sh <= a_sh << DIGIT_W;
                    b_sh <= b_next;
                    cnt  <= cnt + CNT_W'(1);
                    if (last) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clmul_iter.sv
// Bench for clmul_iter at DIGIT_W=8: directed vectors with literal expectations
// plus a polynomial-level reference checked against the outputs every cycle.
module tb_clmul_iter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] a = '0;
    logic [127:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [255:0] product;
    logic         busy;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    clmul_iter #(.DIGIT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .product  (product),
        .busy     (busy)
    );

    // Schoolbook GF(2)[x] product over whole polynomials
    function automatic logic [255:0] clmul(input logic [127:0] x, input logic [127:0] y);
        logic [255:0] r = '0;
        for (int i = 0; i < 128; i++)
            if (y[i]) r = r ^ ({128'b0, x} << i);
        return r;
    endfunction

    // Reduce modulo x^128 + x^7 + x^2 + x + 1
    function automatic logic [127:0] reduce(input logic [255:0] p);
        logic [255:0] r = p;
        for (int i = 255; i >= 128; i--)
            if (r[i]) begin
                r[i] = 1'b0;
                r = r ^ (256'h87 << (i - 128));
            end
        return r[127:0];
    endfunction

    function automatic int lat(input logic [127:0] y);
`ifdef CLMUL_EARLY_EXIT_EN
        int msb = -1;
        for (int i = 0; i < 128; i++)
            if (y[i]) msb = i;
        if (msb < 0) return 1;
        return (msb + 8) / 8;
`else
        return 16;
`endif
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference timeline: 0 idle, 1 computing, 2 result offered
    int           m_phase = 0;
    int           m_left = 0;
    logic [255:0] m_prod = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_left  <= 0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_phase <= 1;
                    m_left  <= lat(b);
                    m_prod  <= clmul(a, b);
                end
                1: if (m_left == 1) m_phase <= 2;
                   else m_left <= m_left - 1;
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_in_ready", {255'b0, in_ready}, {255'b0, m_phase == 0});
            chk("cyc_out_valid", {255'b0, out_valid}, {255'b0, m_phase == 2});
            chk("cyc_busy", {255'b0, busy}, {255'b0, m_phase != 0});
            if (m_phase == 2) chk("cyc_product", product, m_prod);
        end
    end

    logic [255:0] last_prod;

    task automatic run_op(input logic [127:0] ta, input logic [127:0] tb_b,
                          input logic [255:0] ep, input int el,
                          input int hold, input string nm);
        int n = 0;
        while (!in_ready && n < 300) begin
            @(posedge clk); #1; n++;
        end
        chk({nm, "_ready_to"}, {255'b0, in_ready}, 256'h1);
        out_ready = (hold == 0);
        in_valid = 1'b1;
        a = ta;
        b = tb_b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = '1;
        b = '1;
        n = 0;
        while (!out_valid && n < 300) begin
            @(posedge clk); #1; n++;
        end
        chk({nm, "_latency"}, 256'(n), 256'(el));
        chk({nm, "_product"}, product, ep);
        last_prod = product;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({nm, "_hold_prod"}, product, ep);
            chk({nm, "_hold_in_ready"}, {255'b0, in_ready}, 256'h0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({nm, "_post_in_ready"}, {255'b0, in_ready}, 256'h1);
        chk({nm, "_post_out_valid"}, {255'b0, out_valid}, 256'h0);
    endtask

`ifdef CLMUL_EARLY_EXIT_EN
    localparam int L_B3 = 1;
    localparam int L_B0 = 1;
`else
    localparam int L_B3 = 16;
    localparam int L_B0 = 16;
`endif

    initial begin
        logic [127:0] ra, rb;
        #12;
        chk("rst_in_ready", {255'b0, in_ready}, 256'h1);
        chk("rst_out_valid", {255'b0, out_valid}, 256'h0);
        chk("rst_busy", {255'b0, busy}, 256'h0);
        chk("rst_product", product, 256'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(128'h1, 128'h1, 256'h1, 16, 0, "one");
        run_op(128'h2, 128'h1 << 127, 256'h1 << 128, 16, 0, "x128");
        chk("x128_reduce", {128'b0, reduce(last_prod)}, 256'h87);
        run_op('1, '1, {64{4'h5}}, 16, 0, "ones");
        run_op(128'h3, 128'h5, 256'hF, 16, 10, "bp");
        run_op(128'h5, 128'h3, 256'hF, L_B3, 0, "b3");
        run_op(128'hDEAD, 128'h0, 256'h0, L_B0, 0, "b0");
        run_op(128'h1, 128'h1 << 127, 256'h1 << 127, 16, 0, "bmsb");

        // Abort mid-computation
        in_valid = 1'b1;
        a = 128'h1234;
        b = 128'h5678;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {255'b0, out_valid}, 256'h0);
        chk("abort_product", product, 256'h0);
        chk("abort_in_ready", {255'b0, in_ready}, 256'h1);
        chk("abort_busy", {255'b0, busy}, 256'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(128'h3, 128'h5, 256'hF, 16, 0, "after_rst");

        for (int k = 0; k < 6; k++) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            if (k == 0) rb = rb >> 100;
            run_op(ra, rb, clmul(ra, rb), lat(rb), k % 3, "rand");
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
